inst_loader: RTL
================

# inst_loader

Boot-time program loader that fills the instruction memory from a byte stream (UART receiver side) so the CPU can run a new program without resynthesis. It writes the 32-bit instruction words that the instruction decoder later reads. It sits between the UART byte receiver and the instruction-memory write port, and holds the CPU core in reset while a load is in progress.

## Interface
Parameters:
- `ADDR_WIDTH`, default 14: instruction-memory word-address width; legal range 1..16.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load. Honoured only in IDLE, DONE and ERR.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte. A transfer occurs when `rx_valid & rx_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  `REGWIDTH` (32)  instruction word.
- `cpu_hold`  out  1  holds the CPU core in reset while high.
- `done`  out  1  level; last load completed successfully.
- `error`  out  1  level; last load was rejected.
- `words_loaded`  out  ADDR_WIDTH+1  number of words written by the current or last load.

## Operation
Stream format:
- 2-byte little-endian word count N.
- Then 4·N bytes. Each word is sent least-significant byte first, so byte order b0,b1,b2,b3 produces word {b3,b2,b1,b0}.

State machine (states IDLE, HDR0, HDR1, DATA, FLUSH, DONE, ERR):
- IDLE: `rx_ready`=0, `cpu_hold`=0. `start` → HDR0.
- HDR0: `rx_ready`=1. Byte accepted → N[7:0], go to HDR1.
- HDR1: `rx_ready`=1. Byte accepted → N[15:8], then:
  - N=0 → DONE;
  - N > 2^ADDR_WIDTH → ERR;
  - otherwise → DATA.
- DATA: `rx_ready`=1. A 2-bit byte counter packs bytes into a word.
  - On the 4th byte of each word, a registered write is issued: `imem_we`=1 on the next cycle, `imem_addr` = word index, word index incremented.
  - On the 4th byte of word N−1 → FLUSH.
- FLUSH: `rx_ready`=0. Final `imem_we` cycle, then → DONE.
- DONE: `done`=1, `cpu_hold`=0, `rx_ready`=0. `start` → HDR0.
- ERR: `error`=1, `cpu_hold`=1, `rx_ready`=1 (drains and discards bytes), no writes. `start` → HDR0.

Output rules:
- `cpu_hold`=1 in HDR0, HDR1, DATA, FLUSH and ERR.
- Entering HDR0 clears `done`, `error`, `words_loaded`, the word index and the byte counter.
- `words_loaded` increments in the same cycle as each `imem_we`.
- `imem_addr` and `imem_wdata` hold their last value when `imem_we`=0.
- `start` in HDR0, HDR1, DATA or FLUSH is ignored.
- A partially received word is never written.

Width rules:
- Word index is ADDR_WIDTH+1 bits wide, so N = 2^ADDR_WIDTH is legal and fills memory exactly.
- The N comparison is done at 17 bits.

## Timing
- Reset value of every output is 0: `rx_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `cpu_hold`, `done`, `error`, `words_loaded`. State resets to IDLE.
- Reset asserted mid-load: outputs go to 0 immediately (asynchronous); the partial word and the count are discarded; no further `imem_we`.
- Byte acceptance: one byte per cycle maximum. Back-to-back `rx_valid` must be sustained in HDR0, HDR1 and DATA with no lost bytes, including in the cycle where `imem_we` is high.
- Write latency: `imem_we` is high exactly the cycle after the 4th byte of a word is accepted.
- Completion: `done`=1 and `cpu_hold`=0 on the cycle after the final `imem_we`. For N=0, this happens on the cycle after the HDR1 byte.
- `rx_valid` without `rx_ready` has no effect.

## Structure
- State encodings (3-bit) and the header width constant (16) go in the shared `variables.vh`, next to `REGWIDTH`.
- One sub-module is natural: `word_packer`. It contains the byte counter, the 32-bit shift register, the clear input, and a `word_valid` pulse on the 4th byte.
- The top level holds the FSM, the word index and N.

## Test plan
- Reset; `start`; send 02 00 13 05 00 00 93 00 10 00 → `imem_we` twice: addr 0 = 0x00000513, addr 1 = 0x00100093. Then `done`=1, `cpu_hold`=0, `words_loaded`=2.
- `start`; send header 00 00 → no `imem_we`; `done`=1 on the cycle after the 2nd byte; `cpu_hold` high only during HDR0 and HDR1.
- Header 03 00, then 12 bytes with `rx_valid` held high every cycle → `rx_ready` high throughout DATA; `imem_we` exactly 1 cycle after bytes 4, 8 and 12; addresses 0, 1, 2.
- With ADDR_WIDTH=14, header 01 40 (N=16385) → ERR: `error`=1, `cpu_hold`=1, later bytes drained with no writes. Next `start` → `error`=0 and a normal load succeeds. Header 00 40 (N=16384) is accepted.
- Assert `rst_n` low after 6 data bytes → all outputs 0 asynchronously. Restart with N=1 → writes addr 0 only, with the new word.
- `start` pulsed during DATA → ignored; load finishes with the correct `words_loaded`.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: shared constants for the boot-time program loader.
//   REGWIDTH   - instruction word width
//   HDR_WIDTH  - width of the little-endian word-count header
//   S_*        - 3-bit loader state encodings
//   hdr_too_big() - 17-bit comparison of the header count against memory size
package inst_loader_pkg;

  localparam int unsigned REGWIDTH  = 32;
  localparam int unsigned HDR_WIDTH = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // True when the requested word count exceeds 2^aw words (aw <= 16).
  function automatic logic hdr_too_big(input logic [HDR_WIDTH-1:0] n,
                                       input int unsigned aw);
    return {1'b0, n} > (17'd1 << aw);
  endfunction

endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if: byte-stream input and instruction-memory write bus.
//   rx_data/rx_valid/rx_ready - byte handshake from the UART receiver
//   imem_we/imem_addr/imem_wdata - registered instruction-memory write port
//   master modport: the loader; slave modport: the surrounding system.
interface inst_loader_if
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [REGWIDTH-1:0]   imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_loader_word_packer.sv
// word_packer: assembles four LSB-first bytes into one 32-bit word.
//   clk, rst_n    - clock, asynchronous active-low reset
//   clear_i       - discard any partial word and restart at byte 0
//   byte_valid_i  - byte_i is consumed this cycle
//   byte_i        - incoming byte
//   word_valid_o  - pulse on the 4th byte of a word
//   word_o        - completed word {b3,b2,b1,b0}, valid with word_valid_o
module word_packer
  import inst_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_i,
  input  logic                byte_valid_i,
  input  logic [7:0]          byte_i,
  output logic                word_valid_o,
  output logic [REGWIDTH-1:0] word_o
);
  logic [1:0]          cnt_q, cnt_d;
  logic [REGWIDTH-1:0] sr_q, sr_d;

  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (clear_i) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (byte_valid_i) begin
      // Shift in at the top so the first byte ends up in bits [7:0].
      sr_d  = {byte_i, sr_q[REGWIDTH-1:8]};
      cnt_d = cnt_q + 2'd1;
    end
  end

  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
  assign word_o       = {byte_i, sr_q[REGWIDTH-1:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: loads a program image from a byte stream into instruction
// memory and holds the CPU in reset while loading.
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - begin a load (honoured in IDLE, DONE, ERR)
//   bus           - byte handshake in, instruction-memory write out
//   cpu_hold      - CPU reset request while a load is active or rejected
//   done, error   - outcome of the last load
//   words_loaded  - words written by the current or last load
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  inst_loader_if.master       bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);
  logic [2:0]            state_q, state_d;
  logic [HDR_WIDTH-1:0]  n_q, n_d;
  logic [ADDR_WIDTH:0]   widx_q, widx_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REGWIDTH-1:0]   wdata_q, wdata_d;

  logic                  accept;
  logic                  start_ok;
  logic                  pk_valid;
  logic                  word_valid;
  logic [REGWIDTH-1:0]   word;
  logic [HDR_WIDTH-1:0]  n_full;

  assign bus.rx_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                        (state_q == S_DATA) || (state_q == S_ERR);
  assign accept   = bus.rx_valid && bus.rx_ready;
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                              (state_q == S_ERR));
  // Bytes drained in ERR never reach the packer.
  assign pk_valid = accept && (state_q == S_DATA);
  assign n_full   = {bus.rx_data, n_q[7:0]};

  word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_ok),
    .byte_valid_i (pk_valid),
    .byte_i       (bus.rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR0;
          widx_d  = '0;
          n_d     = '0;
        end
      end
      S_HDR0: begin
        if (accept) begin
          n_d[7:0] = bus.rx_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          n_d = n_full;
          if (n_full == '0)                         state_d = S_DONE;
          else if (hdr_too_big(n_full, ADDR_WIDTH)) state_d = S_ERR;
          else                                      state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = widx_q[ADDR_WIDTH-1:0];
          wdata_d = word;
          widx_d  = widx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
          // Last word when index+1 reaches N (compared at 17 bits).
          if (17'(widx_q) + 17'd1 == {1'b0, n_q}) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      widx_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign words_loaded   = widx_q;
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERR);
  assign cpu_hold       = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                          (state_q == S_DATA) || (state_q == S_FLUSH) ||
                          (state_q == S_ERR);
endmodule
